// File: rtl/pair_arb_pkg.sv
// pair_arb_pkg: shared types and defaults for the pair arbiter/sequencer.
//   state_t          - arbiter FSM states (IDLE, GRANT0, GRANT1)
//   HOLD_CYCLES_DEF  - default grant duration in cycles
//   CNT_W_DEF        - default hold-counter width
package pair_arb_pkg;

  localparam int unsigned HOLD_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

endpackage

// File: rtl/pair_arb_sequencer_if.sv
// pair_arb_sequencer_if: signal bundle for the pair arbiter's request/data
// side and its registered outputs. Member names match the block's ports so
// an instance can be wired straight onto pair_arb_sequencer.
//   master : request/data source (drives req*/a..d inputs, observes outputs)
//   slave  : arbiter view (receives requests/data, drives outputs)
interface pair_arb_sequencer_if;

  logic req0_in;
  logic req1_in;
  logic a_in;
  logic b_in;
  logic c_in;
  logic d_in;
  logic a_out;
  logic b_out;
  logic c_out;
  logic d_out;
  logic sel_out;
  logic grant0_out;
  logic grant1_out;
  logic busy_out;

  modport master (
    output req0_in, req1_in, a_in, b_in, c_in, d_in,
    input  a_out, b_out, c_out, d_out, sel_out, grant0_out, grant1_out, busy_out
  );

  modport slave (
    input  req0_in, req1_in, a_in, b_in, c_in, d_in,
    output a_out, b_out, c_out, d_out, sel_out, grant0_out, grant1_out, busy_out
  );

endinterface

// File: rtl/pair_arb_sequencer_hold_cnt.sv
// pair_arb_hold_cnt: grant hold counter.
//   i_clk   - clock (rising edge)
//   i_rst_n - synchronous active-low reset, clears count
//   i_load  - reload count to 0 (wins over i_en)
//   i_en    - increment count
//   o_tc    - terminal count: count == HOLD_CYCLES-1
module pair_arb_hold_cnt #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/pair_arb_sequencer.sv
// pair_arb_sequencer: two-source round-robin arbiter that sequences a pair of
// data bits per source onto a downstream 2:1 mux chain.
//   clk_in, rst_n_in        - clock; synchronous active-low reset
//   req0_in, req1_in        - level requests from source 0 / source 1
//   a_in, c_in / b_in, d_in - data pair of source 0 / source 1
//   a_out..d_out            - registered data, captured while the owner holds grant
//   sel_out                 - mux select (0 = a/c, 1 = b/d), held while idle
//   grant0_out, grant1_out  - one-hot-or-zero grant indication
//   busy_out                - high in either grant state
// Optional feature macro PAIR_ARB_STATS_EN adds gcnt0_out/gcnt1_out, 8-bit
// saturating counts of GRANT0/GRANT1 entries (re-entries included).
module pair_arb_sequencer
  import pair_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       req0_in,
  input  logic       req1_in,
  input  logic       a_in,
  input  logic       c_in,
  input  logic       b_in,
  input  logic       d_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       d_out,
  output logic       sel_out,
  output logic       grant0_out,
  output logic       grant1_out,
  output logic       busy_out
`ifdef PAIR_ARB_STATS_EN
  ,
  output logic [7:0] gcnt0_out,
  output logic [7:0] gcnt1_out
`endif
);

  state_t r_state;
  state_t w_next;
  logic   w_end;
  logic   w_tc;
  logic   r_last;
  logic   r_sel;
  logic   r_a, r_b, r_c, r_d;

  // Counter reloads in IDLE and at every grant end, so each grant (including
  // a re-entry of the same source) starts from 0.
  pair_arb_hold_cnt #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_hold_cnt (
    .i_clk   (clk_in),
    .i_rst_n (rst_n_in),
    .i_load  ((r_state == IDLE) || w_end),
    .i_en    (r_state != IDLE),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_next = r_state;
    w_end  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0_in && req1_in) w_next = r_last ? GRANT0 : GRANT1;
        else if (req0_in)       w_next = GRANT0;
        else if (req1_in)       w_next = GRANT1;
        else                    w_next = IDLE;
      end
      GRANT0: begin
        w_end = w_tc || !req0_in;
        if (w_end) begin
          if (req1_in)      w_next = GRANT1;
          else if (req0_in) w_next = GRANT0;
          else              w_next = IDLE;
        end
      end
      GRANT1: begin
        w_end = w_tc || !req1_in;
        if (w_end) begin
          if (req0_in)      w_next = GRANT0;
          else if (req1_in) w_next = GRANT1;
          else              w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_c     <= 1'b0;
      r_d     <= 1'b0;
    end else begin
      r_state <= w_next;
      // sel and last follow the state being entered so sel lines up with
      // the grant outputs and is simply held through IDLE.
      if (w_next == GRANT0) begin
        r_last <= 1'b0;
        r_sel  <= 1'b0;
      end else if (w_next == GRANT1) begin
        r_last <= 1'b1;
        r_sel  <= 1'b1;
      end
      if (r_state == GRANT0) begin
        r_a <= a_in;
        r_c <= c_in;
      end
      if (r_state == GRANT1) begin
        r_b <= b_in;
        r_d <= d_in;
      end
    end
  end

  assign grant0_out = (r_state == GRANT0);
  assign grant1_out = (r_state == GRANT1);
  assign busy_out   = (r_state != IDLE);
  assign sel_out    = r_sel;
  assign a_out      = r_a;
  assign b_out      = r_b;
  assign c_out      = r_c;
  assign d_out      = r_d;

`ifdef PAIR_ARB_STATS_EN
  logic       w_enter0;
  logic       w_enter1;
  logic [7:0] r_gcnt0;
  logic [7:0] r_gcnt1;

  assign w_enter0 = (w_next == GRANT0) && ((r_state != GRANT0) || w_end);
  assign w_enter1 = (w_next == GRANT1) && ((r_state != GRANT1) || w_end);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
    end else begin
      if (w_enter0 && (r_gcnt0 != '1)) r_gcnt0 <= r_gcnt0 + 1'b1;
      if (w_enter1 && (r_gcnt1 != '1)) r_gcnt1 <= r_gcnt1 + 1'b1;
    end
  end

  assign gcnt0_out = r_gcnt0;
  assign gcnt1_out = r_gcnt1;
`endif

endmodule

// File: tb/tb_pair_arb_sequencer.sv
// Directed bench for pair_arb_sequencer. Output word layout used in checks:
// {grant0, grant1, busy, sel, a, b, c, d}.
module tb_pair_arb_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pair_arb_sequencer_if bus ();

  // Secondary instance with HOLD_CYCLES=1 shares the stimulus.
  logic u1_a, u1_b, u1_c, u1_d, u1_sel, u1_g0, u1_g1, u1_busy;
`ifdef PAIR_ARB_STATS_EN
  logic [7:0] g0cnt, g1cnt, u1_g0cnt, u1_g1cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pair_arb_sequencer #(.HOLD_CYCLES(4), .CNT_W(4)) u_dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .req0_in    (bus.req0_in),
    .req1_in    (bus.req1_in),
    .a_in       (bus.a_in),
    .c_in       (bus.c_in),
    .b_in       (bus.b_in),
    .d_in       (bus.d_in),
    .a_out      (bus.a_out),
    .b_out      (bus.b_out),
    .c_out      (bus.c_out),
    .d_out      (bus.d_out),
    .sel_out    (bus.sel_out),
    .grant0_out (bus.grant0_out),
    .grant1_out (bus.grant1_out),
    .busy_out   (bus.busy_out)
`ifdef PAIR_ARB_STATS_EN
    ,
    .gcnt0_out  (g0cnt),
    .gcnt1_out  (g1cnt)
`endif
  );

  pair_arb_sequencer #(.HOLD_CYCLES(1), .CNT_W(2)) u_dut1 (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .req0_in    (bus.req0_in),
    .req1_in    (bus.req1_in),
    .a_in       (bus.a_in),
    .c_in       (bus.c_in),
    .b_in       (bus.b_in),
    .d_in       (bus.d_in),
    .a_out      (u1_a),
    .b_out      (u1_b),
    .c_out      (u1_c),
    .d_out      (u1_d),
    .sel_out    (u1_sel),
    .grant0_out (u1_g0),
    .grant1_out (u1_g1),
    .busy_out   (u1_busy)
`ifdef PAIR_ARB_STATS_EN
    ,
    .gcnt0_out  (u1_g0cnt),
    .gcnt1_out  (u1_g1cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {bus.grant0_out, bus.grant1_out, bus.busy_out, bus.sel_out,
            bus.a_out, bus.b_out, bus.c_out, bus.d_out};
  endfunction

  function automatic logic [7:0] outs1();
    return {u1_g0, u1_g1, u1_busy, u1_sel, u1_a, u1_b, u1_c, u1_d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r0, input logic r1,
                        input logic a, input logic b, input logic c, input logic d);
    bus.req0_in = r0;
    bus.req1_in = r1;
    bus.a_in    = a;
    bus.b_in    = b;
    bus.c_in    = c;
    bus.d_in    = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  logic       e_g0, e_a, e_d;
  logic [7:0] e_word;

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held 3 cycles with both requests high and data high.
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    do_reset();
    check("reset_outs", 32'(outs()), 32'h00);
    check("reset_outs_h1", 32'(outs1()), 32'h00);
`ifdef PAIR_ARB_STATS_EN
    check("reset_gcnt0", 32'(g0cnt), 32'd0);
`endif

    // Contention: both requests constant, source 0 wins first.
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int unsigned i = 1; i <= 9; i++) begin
      step();
      e_g0   = (((i - 1) % 8) < 4);
      e_a    = (i >= 2);
      e_d    = (i >= 6);
      e_word = {e_g0, ~e_g0, 1'b1, ~e_g0, e_a, 1'b0, 1'b0, e_d};
      check($sformatf("contend_%0d", i), 32'(outs()), 32'(e_word));
      check($sformatf("contend_h1_g0_%0d", i), 32'(u1_g0), 32'(i % 2));
      check($sformatf("contend_h1_g1_%0d", i), 32'(u1_g1), 32'((i + 1) % 2));
    end

    // Single source 1: continuous re-entry, a/c never captured.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int unsigned i = 1; i <= 10; i++) begin
      step();
      e_word = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, (i >= 2), 1'b0, 1'b0};
      check($sformatf("single1_%0d", i), 32'(outs()), 32'(e_word));
    end

    // Early drop of source 0, then contention from IDLE after source 0 was
    // last granted (source 1 wins), then early drop of source 1 (sel held 1).
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); check("drop_g0_c1",   32'(outs()), 32'h A0);
    step(); check("drop_g0_c2",   32'(outs()), 32'h A8);
    bus.req0_in = 1'b0;
    step(); check("drop_g0_idle", 32'(outs()), 32'h 08);
    step(); check("drop_g0_hold", 32'(outs()), 32'h 08);
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(); check("rr_g1_c1",     32'(outs()), 32'h 78);
    step(); check("rr_g1_c2",     32'(outs()), 32'h 7D);
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(); check("drop_g1_idle", 32'(outs()), 32'h 1D);
    step(); check("drop_g1_hold", 32'(outs()), 32'h 1D);

    // Reset during GRANT1 cycle 2, then both requests -> GRANT0 first.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(); check("midrst_c1", 32'(outs()), 32'h 70);
    step(); check("midrst_c2", 32'(outs()), 32'h 75);
    rst_n = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(); check("midrst_rst", 32'(outs()), 32'h 00);
    rst_n = 1'b1;
    step(); check("midrst_g0", 32'(outs()), 32'h A0);

    // Source 0 alone for 300 cycles; HOLD_CYCLES=1 re-enters every cycle.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) step();
    check("long_h1_g0_5", 32'(u1_g0), 32'd1);
    check("long_g0_5",    32'(bus.grant0_out), 32'd1);
`ifdef PAIR_ARB_STATS_EN
    check("stats_h1_g0_5", 32'(u1_g0cnt), 32'd5);
    check("stats_h4_g0_5", 32'(g0cnt), 32'd2);
`endif
    repeat (295) step();
    check("long_h1_g0_300", 32'(outs1()), 32'h A0);
`ifdef PAIR_ARB_STATS_EN
    check("stats_h1_g0_sat", 32'(u1_g0cnt), 32'd255);
    check("stats_h1_g1",     32'(u1_g1cnt), 32'd0);
    check("stats_h4_g1",     32'(g1cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
